// File: rtl/pdp8_iot_ctl.sv
// PDP-8 IOT sequencer: runs IOP1/IOP2/IOP4 pulse phases for one IOT instruction,
// merges device responses into AC/skip, and owns the ION/IOF/SKON interrupt logic.
module pdp8_iot_ctl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] ir,
  input  logic [11:0] ac_in,
  input  logic        int_ack,
  output logic        iot,
  output logic [3:0]  state,
  output logic [11:0] mb,
  output logic [5:0]  io_select,
  output logic [11:0] io_data_in,
  input  logic [11:0] io_data_out,
  input  logic        io_data_avail,
  input  logic        io_skip,
  input  logic        io_clear_ac,
  input  logic        io_interrupt,
  output logic        done,
  output logic [11:0] ac_out,
  output logic        skip,
  output logic        int_enable,
  output logic        int_req
);

  localparam int unsigned WORD_W = 12;
  localparam int unsigned DEV_W  = 6;
  localparam int unsigned PH_W   = 4;

  typedef enum logic [2:0] {S_IDLE, S_P1, S_P2, S_P4, S_DONE} fsm_t;

  fsm_t              r_fsm, w_fsm_nxt;
  logic [WORD_W-1:0] r_mb, r_acc, r_ac_out;
  logic              r_iot, r_done, r_skip, r_skip_acc, r_int_en, r_ion_pend;
  logic [PH_W-1:0]   r_state;

  logic              w_start_ok, w_iot_nxt, w_done_nxt, w_ext_dev;
  logic [PH_W-1:0]   w_state_nxt;
  logic              w_int_p1, w_skon, w_ion, w_iof, w_skip_nxt;
  logic [WORD_W-1:0] w_acc_ph, w_acc_nxt;

  assign w_ext_dev = |r_mb[8:3];

  // Next-state logic; phase outputs are computed one cycle ahead and registered.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_start_ok  = 1'b0;
    w_iot_nxt   = 1'b0;
    w_state_nxt = '0;
    w_done_nxt  = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (start) begin
          w_fsm_nxt   = S_P1;
          w_start_ok  = 1'b1;
          w_iot_nxt   = ir[0] & (|ir[8:3]);
          w_state_nxt = 4'b0001;
        end
      end
      S_P1: begin
        w_fsm_nxt   = S_P2;
        w_iot_nxt   = r_mb[1] & w_ext_dev;
        w_state_nxt = 4'b0010;
      end
      S_P2: begin
        w_fsm_nxt   = S_P4;
        w_iot_nxt   = r_mb[2] & w_ext_dev;
        w_state_nxt = 4'b0100;
      end
      S_P4: begin
        w_fsm_nxt  = S_DONE;
        w_done_nxt = 1'b1;
      end
      S_DONE:  w_fsm_nxt = S_IDLE;
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  // Internal device 00 decode, acted on only in the first phase.
  assign w_int_p1 = (r_fsm == S_P1) && !w_ext_dev;
  assign w_skon   = w_int_p1 && (r_mb[2:0] == 3'b000);
  assign w_ion    = w_int_p1 && (r_mb[2:0] == 3'b001);
  assign w_iof    = w_int_p1 && (r_mb[2:0] == 3'b010);

  // Clear is applied before the OR of device data.
  assign w_acc_ph   = (io_clear_ac ? '0 : r_acc) | (io_data_avail ? io_data_out : '0);
  assign w_acc_nxt  = w_start_ok ? ac_in : (r_iot ? w_acc_ph : r_acc);
  assign w_skip_nxt = w_start_ok ? 1'b0
                    : (r_skip_acc | (r_iot & io_skip) | (w_skon & r_int_en));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fsm      <= S_IDLE;
      r_mb       <= '0;
      r_acc      <= '0;
      r_ac_out   <= '0;
      r_iot      <= 1'b0;
      r_state    <= '0;
      r_done     <= 1'b0;
      r_skip     <= 1'b0;
      r_skip_acc <= 1'b0;
      r_int_en   <= 1'b0;
      r_ion_pend <= 1'b0;
    end else begin
      r_fsm      <= w_fsm_nxt;
      r_iot      <= w_iot_nxt;
      r_state    <= w_state_nxt;
      r_done     <= w_done_nxt;
      r_acc      <= w_acc_nxt;
      r_skip_acc <= w_skip_nxt;
      r_ac_out   <= (r_fsm == S_P4) ? w_acc_nxt : '0;
      r_skip     <= (r_fsm == S_P4) ? w_skip_nxt : 1'b0;
      if (w_start_ok) r_mb <= ir;
      // ION takes effect one instruction late: promoted on the next accepted start.
      if (w_start_ok && r_ion_pend) begin
        r_int_en   <= 1'b1;
        r_ion_pend <= 1'b0;
      end
      if (w_ion) r_ion_pend <= 1'b1;
      if (w_iof || int_ack) begin
        r_int_en   <= 1'b0;
        r_ion_pend <= 1'b0;
      end
    end
  end

  assign iot        = r_iot;
  assign state      = r_state;
  assign mb         = r_mb;
  assign io_select  = DEV_W'(r_mb[8:3]);
  assign io_data_in = r_acc;
  assign done       = r_done;
  assign ac_out     = r_ac_out;
  assign skip       = r_skip;
  assign int_enable = r_int_en;
  assign int_req    = r_int_en & io_interrupt & (r_fsm == S_IDLE);

endmodule

// File: tb/tb_pdp8_iot_ctl.sv
// Self-checking bench for pdp8_iot_ctl: directed scenarios plus randomized IOTs
// checked against an instruction-level model of AC, skip and interrupt state.
module tb_pdp8_iot_ctl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [11:0] ir = '0;
  logic [11:0] ac_in = '0;
  logic        int_ack = 1'b0;
  logic        iot;
  logic [3:0]  state;
  logic [11:0] mb;
  logic [5:0]  io_select;
  logic [11:0] io_data_in;
  logic [11:0] io_data_out = '0;
  logic        io_data_avail = 1'b0;
  logic        io_skip = 1'b0;
  logic        io_clear_ac = 1'b0;
  logic        io_interrupt = 1'b0;
  logic        done;
  logic [11:0] ac_out;
  logic        skip;
  logic        int_enable;
  logic        int_req;

  int checks = 0;
  int errors = 0;
  bit m_ie = 1'b0;
  bit m_pend = 1'b0;

  pdp8_iot_ctl dut (
    .clk(clk), .reset(reset), .start(start), .ir(ir), .ac_in(ac_in), .int_ack(int_ack),
    .iot(iot), .state(state), .mb(mb), .io_select(io_select), .io_data_in(io_data_in),
    .io_data_out(io_data_out), .io_data_avail(io_data_avail), .io_skip(io_skip),
    .io_clear_ac(io_clear_ac), .io_interrupt(io_interrupt), .done(done), .ac_out(ac_out),
    .skip(skip), .int_enable(int_enable), .int_req(int_req)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".mb"}, 32'(mb), 0);
    chk({tag, ".io_data_in"}, 32'(io_data_in), 0);
    chk({tag, ".ac_out"}, 32'(ac_out), 0);
    chk({tag, ".flags"}, {27'd0, iot, done, skip, int_enable, int_req}, 0);
    chk({tag, ".state"}, 32'(state), 0);
  endtask

  task automatic dev_idle();
    io_clear_ac = 1'b0; io_data_avail = 1'b0; io_skip = 1'b0; io_data_out = '0;
  endtask

  // One full IOT: expectations derived per phase from the instruction's IOP bits.
  task automatic run_iot(input logic [11:0] w_ir, input logic [11:0] w_ac,
                         input logic [2:0] clr, input logic [2:0] av, input logic [2:0] sk,
                         input logic [11:0] d0, input logic [11:0] d1, input logic [11:0] d2,
                         input bit extra);
    logic [11:0] acc;
    logic [11:0] dat;
    logic [5:0]  dev;
    bit          skp;
    bit          en;
    dev = w_ir[8:3];
    acc = w_ac;
    skp = 1'b0;
    if (m_pend) begin m_ie = 1'b1; m_pend = 1'b0; end
    start = 1'b1; ir = w_ir; ac_in = w_ac;
    cyc();
    start = 1'b0; ir = 12'($urandom); ac_in = 12'($urandom);
    for (int p = 0; p < 3; p++) begin
      en = (dev != 6'd0) && w_ir[p];
      chk("phase_state", 32'(state), 32'(1 << p));
      chk("phase_iot", 32'(iot), 32'(en));
      chk("phase_mb", 32'(mb), 32'(w_ir));
      chk("phase_io_select", 32'(io_select), 32'(dev));
      chk("phase_io_data_in", 32'(io_data_in), 32'(acc));
      chk("phase_done", 32'(done), 0);
      chk("phase_int_req", 32'(int_req), 0);
      dat = (p == 0) ? d0 : ((p == 1) ? d1 : d2);
      io_clear_ac = clr[p]; io_data_avail = av[p]; io_skip = sk[p]; io_data_out = dat;
      if (p == 0 && extra) begin start = 1'b1; ir = 12'($urandom); ac_in = 12'($urandom); end
      if (en) begin
        if (clr[p]) acc = '0;
        if (av[p]) acc = acc | dat;
        skp = skp | sk[p];
      end
      if (p == 0 && dev == 6'd0) begin
        case (w_ir[2:0])
          3'd0: skp = m_ie;
          3'd1: m_pend = 1'b1;
          3'd2: begin m_ie = 1'b0; m_pend = 1'b0; end
          default: ;
        endcase
      end
      cyc();
      start = 1'b0;
    end
    io_clear_ac = 1'($urandom); io_data_avail = 1'($urandom);
    io_skip = 1'($urandom); io_data_out = 12'($urandom);
    chk("done_pulse", 32'(done), 1);
    chk("done_ac_out", 32'(ac_out), 32'(acc));
    chk("done_skip", 32'(skip), 32'(skp));
    chk("done_state_iot", {27'd0, state, iot}, 0);
    chk("done_int_enable", 32'(int_enable), 32'(m_ie));
    chk("done_mb", 32'(mb), 32'(w_ir));
    cyc();
    dev_idle();
    #1;
    chk("idle_done", 32'(done), 0);
    chk("idle_ac_out", 32'(ac_out), 0);
    chk("idle_skip", 32'(skip), 0);
    chk("idle_io_data_in", 32'(io_data_in), 32'(acc));
    chk("idle_int_req", 32'(int_req), 32'(m_ie & io_interrupt));
  endtask

  initial begin
    logic [11:0] r_ir;
    #12;
    chk_zero("reset");
    @(negedge clk) reset = 1'b1;
    cyc();
    chk_zero("post_reset");

    // Device 04, IOP2+IOP4, no data: AC passes through unchanged.
    run_iot(12'o6046, 12'o0101, 3'b000, 3'b000, 3'b000, 12'o0, 12'o0, 12'o0, 1'b0);
    // Clear in P2, data 0215 in P4.
    run_iot(12'o6036, 12'o7777, 3'b010, 3'b100, 3'b000, 12'o0, 12'o0, 12'o0215, 1'b0);
    // Skip raised in P1 only, then a following IOT with no skip.
    run_iot(12'o6031, 12'o1234, 3'b000, 3'b000, 3'b001, 12'o0, 12'o0, 12'o0, 1'b0);
    run_iot(12'o6031, 12'o1234, 3'b000, 3'b000, 3'b000, 12'o0, 12'o0, 12'o0, 1'b0);

    // ION is delayed by one instruction; int_req only when idle; int_ack clears.
    run_iot(12'o6001, 12'o0, 3'b000, 3'b000, 3'b000, 12'o0, 12'o0, 12'o0, 1'b0);
    chk("ion_delayed", 32'(int_enable), 0);
    io_interrupt = 1'b1;
    run_iot(12'o6041, 12'o0, 3'b000, 3'b000, 3'b000, 12'o0, 12'o0, 12'o0, 1'b0);
    chk("ion_enabled", 32'(int_enable), 1);
    chk("int_req_idle", 32'(int_req), 1);
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0;
    m_ie = 1'b0; m_pend = 1'b0;
    chk("int_ack_ie", 32'(int_enable), 0);
    chk("int_ack_req", 32'(int_req), 0);
    io_interrupt = 1'b0;

    // SKON / IOF / SKON.
    run_iot(12'o6001, 12'o0, 3'b000, 3'b000, 3'b000, 12'o0, 12'o0, 12'o0, 1'b0);
    run_iot(12'o6000, 12'o0, 3'b000, 3'b000, 3'b000, 12'o0, 12'o0, 12'o0, 1'b0);
    chk("skon_on", 32'(int_enable), 1);
    run_iot(12'o6002, 12'o0, 3'b000, 3'b000, 3'b000, 12'o0, 12'o0, 12'o0, 1'b0);
    chk("iof_off", 32'(int_enable), 0);
    run_iot(12'o6000, 12'o0, 3'b000, 3'b000, 3'b000, 12'o0, 12'o0, 12'o0, 1'b0);

    // Extra start during P1 is dropped.
    run_iot(12'o6057, 12'o0707, 3'b111, 3'b111, 3'b010, 12'o0001, 12'o0020, 12'o0400, 1'b1);

    // Reset during P2 aborts with no done; a new IOT is accepted afterwards.
    start = 1'b1; ir = 12'o6046; ac_in = 12'o0101;
    cyc();
    start = 1'b0;
    cyc();
    reset = 1'b0;
    #1;
    chk_zero("abort");
    cyc();
    @(negedge clk) reset = 1'b1;
    m_ie = 1'b0; m_pend = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("abort_no_done", 32'(done), 0);
    end
    run_iot(12'o6044, 12'o0011, 3'b000, 3'b100, 3'b000, 12'o0, 12'o0, 12'o0600, 1'b0);

    // Randomized IOTs, including internal device 00 and ignored responses.
    for (int i = 0; i < 60; i++) begin
      r_ir = {3'b110, (($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63))),
              3'($urandom)};
      io_interrupt = 1'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        int_ack = 1'b1;
        cyc();
        int_ack = 1'b0;
        m_ie = 1'b0; m_pend = 1'b0;
        chk("rand_int_ack", 32'(int_enable), 0);
      end
      run_iot(r_ir, 12'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
              12'($urandom), 12'($urandom), 12'($urandom), 1'($urandom));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
